uart_rx_ctrl: RTL and testbench

- Drain controller and receive buffer between the serial receiver and the CPU bus.
- Watches the receiver's `full` flag, pulses its read-enable, and pushes each byte into a DEPTH-entry FIFO.
- Exposes data, status and control registers, and raises an interrupt.
- Sits between uart_rx and the RISC-V peripheral bus decoder.

---
 rtl/uart_rx_ctrl_if.sv | 25 ++
 rtl/uart_rx_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: groups the receiver handshake (rx_full/rx_dout/rx_re)
// and the CPU register bus (cs/wr/addr/wdata/rdata) plus the interrupt
// line into one bundle. The slave modport is the controller's view; the
// master modport is the view of whatever drives the receiver and the bus.
interface uart_rx_ctrl_if;
  logic       rx_full;
  logic [7:0] rx_dout;
  logic       rx_re;
  logic       cs;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  modport slave (
    input  rx_full, rx_dout, cs, wr, addr, wdata,
    output rx_re, rdata, irq
  );

  modport master (
    output rx_full, rx_dout, cs, wr, addr, wdata,
    input  rx_re, rdata, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: drains bytes from the serial receiver into a 2**ADDR_W deep
// FIFO and exposes DATA (0), STATUS (1) and CTRL (2) registers plus an
// interrupt to the CPU bus.
// Optional build macro RX_TIMEOUT_EN adds an idle timeout flag (tmo) that
// sets TIMEOUT_CLKS clocks after the last push/pop while data is waiting.
// Without the macro tmo is tied low and TIMEOUT_CLKS has no effect.
module uart_rx_ctrl #(
  parameter int ADDR_W       = 3,
  parameter int TIMEOUT_CLKS = 4000
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t              state;
  state_t              state_next;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W-1:0]   rptr;
  logic [ADDR_W:0]     level;
  logic                ovf;
  logic                tmo;
  logic                irq_en;
  logic [7:0]          rdata_q;
  logic                irq_q;

  logic                sample;
  logic                rd;
  logic                wr_en;
  logic                pop;
  logic                push;
  logic                drop;
  logic                flush;
  logic                ovf_clr;
  logic                not_empty;
  logic                fifo_full;
  logic [4:0]          level_ext;
  logic [3:0]          level_sat;
  logic [7:0]          status;
  logic [7:0]          rd_next;

  // Drain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Drain FSM: strobe rx_re for one cycle when a byte waits, then one ACK
  // cycle so the receiver can drop rx_full. rx_re is held low in reset.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_full && !rst) begin
          sample     = 1'b1;
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.rx_re = sample;

  // Bus decode, push/pop arbitration and register read mux.
  always_comb begin
    rd        = bus.cs & ~bus.wr;
    wr_en     = bus.cs & bus.wr;
    not_empty = (level != '0);
    fifo_full = (level == (ADDR_W+1)'(DEPTH));
    pop       = rd & (bus.addr == 2'd0) & not_empty;
    flush     = wr_en & (bus.addr == 2'd2) & bus.wdata[1];
    push      = sample & ~flush & (~fifo_full | pop);
    drop      = sample & ~flush & fifo_full & ~pop;
    ovf_clr   = wr_en & (bus.addr == 2'd1) & bus.wdata[2];
    level_ext = 5'(level);
    if (level_ext[4]) begin
      level_sat = 4'hF;
    end else begin
      level_sat = level_ext[3:0];
    end
    status = {level_sat, tmo, ovf, fifo_full, not_empty};
    case (bus.addr)
      2'd0: begin
        if (not_empty) begin
          rd_next = mem[rptr];
        end else begin
          rd_next = 8'h00;
        end
      end
      2'd1:    rd_next = status;
      2'd2:    rd_next = {7'b0000000, irq_en};
      default: rd_next = 8'h00;
    endcase
  end

  // FIFO storage; contents are only meaningful between rptr and wptr.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bus.rx_dout;
    end
  end

  // FIFO pointers and fill level; flush empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag (a set beats a same-cycle clear) and irq enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (wr_en && (bus.addr == 2'd2)) begin
        irq_en <= bus.wdata[0];
      end
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_set;
  logic             tmo_clr;

  // Timeout fires once, on the clock where the idle count reaches its limit.
  always_comb begin
    tmo_clr = wr_en & (bus.addr == 2'd1) & bus.wdata[3];
    tmo_set = not_empty & ~push & ~pop & ~flush &
              (tmo_cnt == CNT_W'(TIMEOUT_CLKS - 1));
  end

  // Idle counter: restarts on any buffer activity, saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (flush || push || pop || !not_empty) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != CNT_W'(TIMEOUT_CLKS)) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag; flush clears it outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo <= 1'b0;
    end else if (flush) begin
      tmo <= 1'b0;
    end else if (tmo_set) begin
      tmo <= 1'b1;
    end else if (tmo_clr) begin
      tmo <= 1'b0;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Registered bus outputs: rdata holds until the next read; irq lags by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      if (rd) begin
        rdata_q <= rd_next;
      end
      irq_q <= irq_en & (not_empty | ovf | tmo);
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: drives a behavioural receiver and random/directed bus
// traffic into uart_rx_ctrl, predicts every output cycle by cycle from a
// queue-based model of the buffer, and pins the model with literal values.
module tb_uart_rx_ctrl;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int TO     = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CLKS(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] q[$];
  bit         m_ovf = 0, m_tmo = 0, m_ien = 0, m_cool = 0, m_irq = 0;
  logic [7:0] m_rdata = 8'h00;
  int         m_age = 0;
  int         lvl0;
  bit         s_strobe, s_rd, s_wr, s_pop, s_flush, s_acc, s_ovf_set, s_tmo_set;
  logic [7:0] s_status;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf = 0; m_tmo = 0; m_ien = 0; m_cool = 0; m_irq = 0;
      m_rdata = 8'h00; m_age = 0;
    end else begin
      lvl0      = q.size();
      s_strobe  = !m_cool && bus.rx_full;
      s_rd      = bus.cs && !bus.wr;
      s_wr      = bus.cs && bus.wr;
      s_pop     = s_rd && bus.addr == 2'd0 && lvl0 > 0;
      s_flush   = s_wr && bus.addr == 2'd2 && bus.wdata[1];
      s_acc     = s_strobe && !s_flush && (lvl0 < DEPTH || s_pop);
      s_ovf_set = s_strobe && !s_flush && !s_acc;
      s_tmo_set = 0;
      s_status  = 8'((lvl0 > 15 ? 15 : lvl0) * 16) | 8'(m_tmo * 8) | 8'(m_ovf * 4)
                  | 8'((lvl0 == DEPTH) * 2) | 8'(lvl0 > 0);
      if (s_rd) begin
        case (bus.addr)
          2'd0:    m_rdata = (lvl0 > 0) ? q[0] : 8'h00;
          2'd1:    m_rdata = s_status;
          2'd2:    m_rdata = 8'(m_ien);
          default: m_rdata = 8'h00;
        endcase
      end
      m_irq = m_ien && (lvl0 > 0 || m_ovf || m_tmo);
`ifdef RX_TIMEOUT_EN
      if (s_acc || s_pop || s_flush || lvl0 == 0) m_age = 0;
      else if (m_age < TO) begin
        m_age++;
        if (m_age == TO) s_tmo_set = 1;
      end
`endif
      if (s_pop) void'(q.pop_front());
      if (s_acc) q.push_back(bus.rx_dout);
      if (s_flush) q.delete();
      if (s_ovf_set) m_ovf = 1;
      else if (s_wr && bus.addr == 2'd1 && bus.wdata[2]) m_ovf = 0;
      if (s_flush) m_tmo = 0;
      else if (s_tmo_set) m_tmo = 1;
      else if (s_wr && bus.addr == 2'd1 && bus.wdata[3]) m_tmo = 0;
      if (s_wr && bus.addr == 2'd2) m_ien = bus.wdata[0];
      m_cool = s_strobe;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit re_seen = 0;
  always @(negedge clk) begin
    chk("rdata", bus.rdata, m_rdata);
    chk("irq", bus.irq, m_irq);
    chk("rx_re", bus.rx_re, (!rst && !m_cool && bus.rx_full));
    re_seen = bus.rx_re;
  end

  // ---------------- receiver stub and bus driver ----------------
  logic [7:0] pend[$];
  int gap = 0;
  bit rand_gap = 0;

  task automatic step(input bit c, input bit w, input logic [1:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    if (bus.rx_full && re_seen) begin
      bus.rx_full = 1'b0;
      gap = rand_gap ? int'($urandom_range(0, 4)) : 0;
    end
    if (!bus.rx_full) begin
      if (gap > 0) gap--;
      else if (pend.size() > 0) begin
        bus.rx_full = 1'b1;
        bus.rx_dout = pend.pop_front();
      end
    end
    bus.cs = c; bus.wr = w; bus.addr = a; bus.wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic read_chk(input logic [1:0] a, input logic [7:0] exp, input string name);
    step(1'b1, 1'b0, a, 8'h00);
    step(1'b0, 1'b0, 2'd0, 8'h00);
    chk(name, bus.rdata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int k;
    int r;
    bus.rx_full = 1'b0; bus.rx_dout = 8'h00;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;
    idle(3);
    rst = 1'b0;
    chk("reset_rdata", bus.rdata, 8'h00);
    chk("reset_irq", bus.irq, 1'b0);

    // single byte
    write(2'd2, 8'h01);
    pend.push_back(8'hA5);
    idle(4);
    read_chk(2'd1, 8'h11, "single_status");
    chk("single_irq", bus.irq, 1'b1);
    read_chk(2'd0, 8'hA5, "single_data");
    read_chk(2'd1, 8'h00, "single_status_after");
    idle(1);
    chk("single_irq_drop", bus.irq, 1'b0);

    // fill and overflow
    for (int i = 1; i <= 9; i++) pend.push_back(8'(i));
    idle(25);
    read_chk(2'd1, 8'h87, "ovf_status");
    for (int i = 1; i <= 8; i++) read_chk(2'd0, 8'(i), "ovf_data");
    read_chk(2'd0, 8'h00, "ovf_empty_read");
    write(2'd1, 8'h04);
    read_chk(2'd1, 8'h00, "ovf_cleared");

    // simultaneous push and pop at full
    for (int i = 0; i < 8; i++) pend.push_back(8'h10 + 8'(i));
    idle(20);
    read_chk(2'd1, 8'h83, "full_status");
    pend.push_back(8'h18);
    step(1'b1, 1'b0, 2'd0, 8'h00);
    idle(1);
    chk("simul_rx_oldest", bus.rdata, 8'h10);
    read_chk(2'd1, 8'h83, "simul_status");
    for (int i = 1; i <= 8; i++) read_chk(2'd0, 8'h10 + 8'(i), "simul_order");
    read_chk(2'd1, 8'h00, "simul_drained");

    // wrap-around: each byte read one cycle after it lands
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      pend.push_back(b);
      idle(1);
      step(1'b1, 1'b0, 2'd0, 8'h00);
      idle(1);
      chk("wrap_data", bus.rdata, b);
    end

    // randomized traffic
    rand_gap = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) pend.push_back(8'($urandom));
      r = ((i / 300) % 2 == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 40));
      if (r == 4 || r == 5) step(1'b1, 1'b0, 2'd0, 8'h00);
      else if (r == 6) step(1'b1, 1'b0, 2'd1, 8'h00);
      else if (r == 7) step(1'b1, 1'b0, 2'($urandom), 8'h00);
      else if (r == 8) write(2'd1, 8'($urandom));
      else if (r == 9) write(2'($urandom), 8'($urandom) & 8'hFD | (($urandom_range(0, 7) == 0) ? 8'h02 : 8'h00));
      else idle(1);
    end
    rand_gap = 0;
    k = 0;
    while ((pend.size() > 0 || bus.rx_full) && k < 3000) begin
      idle(1);
      k++;
    end
    chk("drain_bound", (k < 3000), 1'b1);
    idle(2);
    write(2'd2, 8'h03);
    write(2'd1, 8'h0C);
    read_chk(2'd1, 8'h00, "post_rand_status");

    // flush
    for (int i = 0; i < 3; i++) pend.push_back(8'hC0 + 8'(i));
    idle(10);
    read_chk(2'd1, 8'h31, "pre_flush_status");
    write(2'd2, 8'h03);
    read_chk(2'd1, 8'h00, "flush_status");
    read_chk(2'd2, 8'h01, "flush_ien");

    // reset mid-burst
    for (int i = 0; i < 6; i++) pend.push_back(8'h60 + 8'(i));
    idle(5);
    step(1'b1, 1'b0, 2'd1, 8'h00);
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_irq", bus.irq, 1'b0);
    chk("rst_rx_re", bus.rx_re, 1'b0);
    idle(2);
    rst = 1'b0;
    idle(30);
    step(1'b1, 1'b0, 2'd1, 8'h00);
    idle(1);
    chk("rst_drained", bus.rdata[0], 1'b1);
    write(2'd2, 8'h03);
    write(2'd1, 8'h0C);
    idle(3);

    // timeout
    pend.push_back(8'h5A);
    idle(1);
`ifdef RX_TIMEOUT_EN
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 2'd1, 8'h00);
    step(1'b1, 1'b0, 2'd1, 8'h00);
    chk("tmo_not_yet", bus.rdata, 8'h11);
    idle(1);
    chk("tmo_set", bus.rdata, 8'h19);
    write(2'd1, 8'h08);
    read_chk(2'd1, 8'h11, "tmo_cleared");
`else
    idle(120);
    read_chk(2'd1, 8'h11, "no_tmo");
`endif
    read_chk(2'd0, 8'h5A, "tmo_data");
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
